uart_line_reader: RTL and testbench

- Downstream consumer of the UART receive ring buffer. It pops bytes through the buffer's get/data/empty interface and assembles them into one text line with line editing.
- Exposes the completed line to the game logic via a valid/ready handshake and a combinational character read port.
- Used by the text-game command front end.

---
 rtl/uart_line_reader.sv | 132 +++++++++++++
 tb/tb_uart_line_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_line_reader.sv
// uart_line_reader: pops receive-buffer bytes and assembles one editable text line for the game front end.
// Define UART_LINE_ECHO_EN to echo accepted edits on tx_data/tx_start (default build has no echo).
module uart_line_reader #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_empty,
  output logic                       rx_get,
  output logic                       line_valid,
  input  logic                       line_ready,
  output logic [LEN_W-1:0]           line_len,
  output logic                       line_ovf,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy
);
  localparam int AW = $clog2(MAX_LEN);
  typedef enum logic [1:0] {
    COLLECT,
`ifdef UART_LINE_ECHO_EN
    ECHO,
`endif
    DONE
  } state_t;
  state_t state;
  logic [7:0] mem [MAX_LEN];
  logic is_term, is_bs, is_pr, full, store;
  always_comb begin
    is_term = rx_data == 8'h0D || rx_data == 8'h0A;
    is_bs = rx_data == 8'h08 || rx_data == 8'h7F;
    is_pr = rx_data >= 8'h20 && rx_data <= 8'h7E;
    full = line_len == LEN_W'(MAX_LEN);
  end
  assign rx_get = resetn && state == COLLECT && !rx_empty;
  assign store = rx_get && is_pr && !full;
  assign rd_data = mem[rd_addr];
  always_ff @(posedge clk)
    if (store) mem[line_len[AW-1:0]] <= rx_data;
`ifdef UART_LINE_ECHO_EN
  // echo queue: low byte goes out first
  logic [23:0] eq;
  logic [1:0] eq_n, ph;
  logic term_pend;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = tx_busy;
  assign tx_data = 8'h00;
  assign tx_start = 1'b0;
`endif
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= COLLECT;
      line_len <= '0;
      line_ovf <= 1'b0;
      line_valid <= 1'b0;
`ifdef UART_LINE_ECHO_EN
      tx_start <= 1'b0;
      tx_data <= 8'h00;
      eq <= '0;
      eq_n <= '0;
      ph <= '0;
      term_pend <= 1'b0;
`endif
    end else begin
`ifdef UART_LINE_ECHO_EN
      tx_start <= 1'b0;
`endif
      case (state)
        COLLECT: if (rx_get) begin
          if (is_term && line_len != '0) begin
`ifdef UART_LINE_ECHO_EN
            state <= ECHO;
            eq <= 24'h000A0D;
            eq_n <= 2'd2;
            term_pend <= 1'b1;
`else
            state <= DONE;
            line_valid <= 1'b1;
`endif
          end else if (is_bs && line_len != '0) begin
            line_len <= line_len - LEN_W'(1);
`ifdef UART_LINE_ECHO_EN
            state <= ECHO;
            eq <= 24'h082008;
            eq_n <= 2'd3;
            term_pend <= 1'b0;
`endif
          end else if (store) begin
            line_len <= line_len + LEN_W'(1);
`ifdef UART_LINE_ECHO_EN
            state <= ECHO;
            eq <= {16'h0000, rx_data};
            eq_n <= 2'd1;
            term_pend <= 1'b0;
`endif
          end else if (is_pr) line_ovf <= 1'b1;
        end
`ifdef UART_LINE_ECHO_EN
        // one byte per tx_busy rise/fall cycle
        ECHO: begin
          if (ph == 2'd0 && !tx_busy) begin
            tx_start <= 1'b1;
            tx_data <= eq[7:0];
            ph <= 2'd1;
          end else if (ph == 2'd1 && tx_busy) ph <= 2'd2;
          else if (ph == 2'd2 && !tx_busy) begin
            eq <= eq >> 8;
            eq_n <= eq_n - 2'd1;
            ph <= 2'd0;
            if (eq_n == 2'd1) begin
              state <= term_pend ? DONE : COLLECT;
              line_valid <= term_pend;
            end
          end
        end
`endif
        DONE: if (line_ready) begin
          state <= COLLECT;
          line_valid <= 1'b0;
          line_len <= '0;
          line_ovf <= 1'b0;
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_line_reader.sv
// tb_uart_line_reader: directed line-assembly vectors against a model receive buffer and echo transmitter.
module tb_uart_line_reader;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic line_ready = 1'b0;
  logic [3:0] rd_addr = 4'd0;
  logic rx_empty, rx_get, line_valid, line_ovf, tx_start, tx_busy;
  logic [7:0] rx_data, rd_data, tx_data;
  logic [4:0] line_len;
  logic [7:0] src [256];
  logic [7:0] tx_log [16];
  int wr_ptr = 0, rd_ptr = 0, tx_n = 0, busy_cnt = 0;
  int n_chk = 0, n_ok = 0;

  uart_line_reader dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_empty(rx_empty), .rx_get(rx_get),
    .line_valid(line_valid), .line_ready(line_ready), .line_len(line_len), .line_ovf(line_ovf),
    .rd_addr(rd_addr), .rd_data(rd_data), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;
  assign rx_empty = rd_ptr == wr_ptr;
  assign rx_data = src[rd_ptr[7:0]];
  assign tx_busy = busy_cnt != 0;
  always @(posedge clk) begin
    if (rx_get) rd_ptr <= rd_ptr + 1;
    if (tx_start) begin
      tx_log[tx_n[3:0]] <= tx_data;
      tx_n <= tx_n + 1;
      busy_cnt <= 10;
    end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_ok++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push(input logic [7:0] b);
    src[wr_ptr[7:0]] = b;
    wr_ptr++;
  endtask

  task automatic push_s(input string s);
    for (int i = 0; i < s.len(); i++) push(s[i]);
  endtask

  task automatic rd(input string tag, input int a, input int e);
    rd_addr = a[3:0];
    #1;
    chk(tag, int'(rd_data), e);
  endtask

  task automatic wait_line(input string tag);
    int k = 0;
    while (!line_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " valid"}, int'(line_valid), 1);
  endtask

  task automatic ack();
    line_ready = 1'b1;
    @(negedge clk);
    line_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst valid", int'(line_valid), 0);
    chk("rst len", int'(line_len), 0);
    chk("rst ovf", int'(line_ovf), 0);
    chk("rst get", int'(rx_get), 0);
    chk("rst tx_start", int'(tx_start), 0);
    resetn = 1'b1;
`ifdef UART_LINE_ECHO_EN
    push_s("a"); push(8'h08); push(8'h0D);
    for (int k = 0; k < 300 && !(tx_n >= 4 && busy_cnt == 0); k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("e1 tx count", tx_n, 4);
    chk("e1 tx0", int'(tx_log[0]), 8'h61);
    chk("e1 tx1", int'(tx_log[1]), 8'h08);
    chk("e1 tx2", int'(tx_log[2]), 8'h20);
    chk("e1 tx3", int'(tx_log[3]), 8'h08);
    chk("e1 no line", int'(line_valid), 0);
    chk("e1 len", int'(line_len), 0);
    push_s("b"); push(8'h0D);
    wait_line("e2");
    chk("e2 echo done", busy_cnt, 0);
    chk("e2 tx count", tx_n, 7);
    chk("e2 tx4", int'(tx_log[4]), 8'h62);
    chk("e2 tx5", int'(tx_log[5]), 8'h0D);
    chk("e2 tx6", int'(tx_log[6]), 8'h0A);
    chk("e2 len", int'(line_len), 1);
    rd("e2 char0", 0, 8'h62);
    ack();
`else
    push_s("go"); push(8'h0D); push_s("x");
    @(negedge clk);
    chk("t1 len1", int'(line_len), 1);
    @(negedge clk);
    chk("t1 pre valid", int'(line_valid), 0);
    chk("t1 get cr", int'(rx_get), 1);
    chk("t1 cr head", int'(rx_data), 8'h0D);
    @(negedge clk);
    chk("t1 valid", int'(line_valid), 1);
    chk("t1 len", int'(line_len), 2);
    rd("t1 char0", 0, 8'h67);
    rd("t1 char1", 1, 8'h6F);
    repeat (3) @(negedge clk);
    chk("t1 hold get", int'(rx_get), 0);
    chk("t1 hold ptr", rd_ptr, 3);
    chk("t1 hold valid", int'(line_valid), 1);
    ack();
    chk("t1 ack valid", int'(line_valid), 0);
    chk("t1 ack len", int'(line_len), 0);
    chk("t1 get x", int'(rx_get), 1);
    @(negedge clk);
    chk("t1 x ptr", rd_ptr, 4);
    chk("t1 x len", int'(line_len), 1);
    push(8'h0D);
    wait_line("t1b");
    rd("t1b char0", 0, 8'h78);
    ack();
    push(8'h0D); push(8'h0A); push(8'h0D); push(8'h0A); push_s("ab"); push(8'h0A);
    wait_line("t2");
    chk("t2 len", int'(line_len), 2);
    rd("t2 char0", 0, 8'h61);
    rd("t2 char1", 1, 8'h62);
    ack();
    repeat (5) @(negedge clk);
    chk("t2 no empty line", int'(line_valid), 0);
    chk("t2 drained", int'(rx_empty), 1);
    push_s("abc");
    line_ready = 1'b1;
    repeat (3) @(negedge clk);
    line_ready = 1'b0;
    chk("t3 ready ignored", int'(line_len), 3);
    push(8'h08); push(8'h7F); push(8'h01); push(8'h08); push(8'h08); push_s("z"); push(8'h0D);
    wait_line("t3");
    chk("t3 len", int'(line_len), 1);
    rd("t3 char0", 0, 8'h7A);
    chk("t3 ovf", int'(line_ovf), 0);
    ack();
    for (int i = 0; i < 20; i++) push(8'h41 + 8'(i));
    push(8'h0D);
    wait_line("t4");
    chk("t4 len", int'(line_len), 16);
    rd("t4 char0", 0, 8'h41);
    rd("t4 char15", 15, 8'h50);
    chk("t4 ovf", int'(line_ovf), 1);
    ack();
    chk("t4 ovf clr", int'(line_ovf), 0);
    chk("t4 len clr", int'(line_len), 0);
    push_s("ab");
    repeat (3) @(negedge clk);
    chk("t5 partial", int'(line_len), 2);
    resetn = 1'b0;
    #1;
    chk("t5 rst len", int'(line_len), 0);
    chk("t5 rst valid", int'(line_valid), 0);
    chk("t5 rst get", int'(rx_get), 0);
    @(negedge clk);
    resetn = 1'b1;
    push_s("c"); push(8'h0D);
    wait_line("t5");
    chk("t5 len", int'(line_len), 1);
    rd("t5 char0", 0, 8'h63);
    resetn = 1'b0;
    #1;
    chk("t5 done rst valid", int'(line_valid), 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("t5 idle valid", int'(line_valid), 0);
    chk("t5 idle len", int'(line_len), 0);
    chk("no echo", tx_n, 0);
`endif
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
